systolic_drain: RTL and testbench

//   Reader/drain end of the ternary systolic array's result interface.
//   - On a capture pulse: snapshots the full psum grid (Y_out) and issues a one-cycle accumulator clear to the array.
//   - Requantises each psum (arithmetic shift, then saturate).
//   - Streams the grid out one row (HIDDEN index) per beat over a valid/ready channel.
//   - Sits between SystolicArray.Y_out/rst and the downstream activation/writeback path.

---
 rtl/systolic_drain.sv | 153 +++++++++++++++
 tb/tb_systolic_drain.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// systolic_drain: result drain for the ternary systolic array.
// On a capture pulse the psum grid is snapshotted and the array accumulators
// are cleared for one cycle. The snapshot is then requantised (arithmetic
// shift right, saturate) and streamed out one row per valid/ready beat.
module systolic_drain #(
    parameter int WIDTH          = 16,
    parameter int HIDDEN_SIZE    = 4,
    parameter int CONTEXT_LENGTH = 4,
    parameter int OUT_WIDTH      = 16,
    parameter int SHW            = $clog2(2*WIDTH)
) (
    input  logic                                                     clock,
    input  logic                                                     rst_n,
    input  logic                                                     capture,
    input  logic [SHW-1:0]                                           shift,
    input  logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][2*WIDTH-1:0]  y_in,
    output logic                                                     arr_clr,
    output logic                                                     busy,
    output logic                                                     m_valid,
    input  logic                                                     m_ready,
    output logic [CONTEXT_LENGTH-1:0][OUT_WIDTH-1:0]                 m_data,
    output logic [(HIDDEN_SIZE > 1 ? $clog2(HIDDEN_SIZE) : 1)-1:0]   m_row,
    output logic                                                     m_last,
    output logic                                                     m_sat
);

    localparam int PW    = 2*WIDTH;
    localparam int ROW_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;

    // Saturation bounds expressed at psum width.
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   vld_p1;
    logic   row_last;

    logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][PW-1:0] snap_p0;
    logic [SHW-1:0]                                     shift_p0;
    logic [ROW_W-1:0]                                   row_p0;
    logic [CONTEXT_LENGTH-1:0]                          lane_sat;

    // Shift amounts past the psum width would only replicate the sign bit.
    function automatic int clamp_shift(input int s);
        return (s > PW-1) ? PW-1 : s;
    endfunction

    function automatic logic signed [PW-1:0] ashr(input logic signed [PW-1:0] y,
                                                  input logic [SHW-1:0] sh);
        return y >>> sh;
    endfunction

    function automatic logic sat_hit(input logic signed [PW-1:0] r);
        return (r > SAT_MAX) || (r < SAT_MIN);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [PW-1:0] r);
        if (r > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return r[OUT_WIDTH-1:0];
    endfunction

    assign vld_p1   = (state == STREAM);
    assign row_last = (row_p0 == ROW_W'(HIDDEN_SIZE-1));

    // FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; capture is only honoured from IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (m_ready && row_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage p0: snapshot grid and shift, request one-cycle array clear ----
    // Snapshot capture and clear request; arr_clr holds high through reset
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            snap_p0  <= '0;
            shift_p0 <= '0;
            arr_clr  <= 1'b1;
        end else begin
            arr_clr <= accept;
            if (accept) begin
                snap_p0  <= y_in;
                shift_p0 <= SHW'(clamp_shift(int'(shift)));
            end
        end
    end

    // Row pointer advances on each handshake and wraps after the last row
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            row_p0 <= '0;
        end else if (vld_p1 && m_ready) begin
            row_p0 <= row_last ? '0 : row_p0 + ROW_W'(1);
        end
    end

    // ---- stage p1: requantise the selected snapshot row ----
    // Per-lane shift and saturate of the row being presented
    always_comb begin
        m_data   = '0;
        lane_sat = '0;
        for (int j = 0; j < CONTEXT_LENGTH; j++) begin
            m_data[j]   = saturate(ashr($signed(snap_p0[row_p0][j]), shift_p0));
            lane_sat[j] = sat_hit(ashr($signed(snap_p0[row_p0][j]), shift_p0));
        end
    end

    assign busy    = (state != IDLE);
    assign m_valid = vld_p1;
    assign m_row   = row_p0;
    assign m_last  = vld_p1 && row_last;
    assign m_sat   = vld_p1 && (|lane_sat);

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: scoreboard of expected beats built from an
// independent integer model of shift/saturate, consumed as beats handshake.
module tb_systolic_drain;

    localparam int WIDTH = 16;
    localparam int H     = 4;
    localparam int C     = 4;
    localparam int OW    = 16;
    localparam int SHW   = $clog2(2*WIDTH);
    localparam int RW    = 2;
    localparam longint MAXV = (64'sd1 <<< (OW-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OW-1));

    typedef logic [H-1:0][C-1:0][2*WIDTH-1:0] grid_t;
    typedef struct packed {
        logic [RW-1:0]         row;
        logic [C-1:0][OW-1:0]  data;
        logic                  last;
        logic                  sat;
    } beat_t;

    logic                  clock = 1'b0;
    logic                  rst_n;
    logic                  capture;
    logic [SHW-1:0]        shift;
    grid_t                 y_in;
    logic                  arr_clr;
    logic                  busy;
    logic                  m_valid;
    logic                  m_ready;
    logic [C-1:0][OW-1:0]  m_data;
    logic [RW-1:0]         m_row;
    logic                  m_last;
    logic                  m_sat;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    systolic_drain #(
        .WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(C), .OUT_WIDTH(OW), .SHW(SHW)
    ) dut (
        .clock(clock), .rst_n(rst_n), .capture(capture), .shift(shift), .y_in(y_in),
        .arr_clr(arr_clr), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_row(m_row), .m_last(m_last), .m_sat(m_sat)
    );

    always #5 clock = ~clock;

    // Floor division by 2^sh then clamp, done in 64-bit integers.
    function automatic void model_lane(input logic [2*WIDTH-1:0] y, input int sh,
                                       output logic [OW-1:0] r, output logic s);
        longint v = longint'($signed(y));
        longint d = longint'(1) << sh;
        longint q;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        s = 1'b0;
        if (q > MAXV) begin q = MAXV; s = 1'b1; end
        else if (q < MINV) begin q = MINV; s = 1'b1; end
        r = q[OW-1:0];
    endfunction

    function automatic void push_grid(input grid_t g, input int sh);
        for (int i = 0; i < H; i++) begin
            beat_t      b;
            logic [OW-1:0] r;
            logic       s;
            b.row  = RW'(i);
            b.last = (i == H-1);
            b.sat  = 1'b0;
            for (int j = 0; j < C; j++) begin
                model_lane(g[i][j], sh, r, s);
                b.data[j] = r;
                b.sat     = b.sat | s;
            end
            sb.push_back(b);
        end
    endfunction

    function automatic grid_t rand_grid(input int span);
        grid_t g;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < C; j++)
                g[i][j] = 32'($urandom_range(0, 2*span)) - 32'(span);
        return g;
    endfunction

    task automatic do_capture(input grid_t g, input logic [SHW-1:0] sh);
        @(negedge clock);
        y_in    = g;
        shift   = sh;
        capture = 1'b1;
        @(negedge clock);
        capture = 1'b0;
        y_in    = rand_grid(100000);
        shift   = SHW'($urandom);
        checks++;
        if (arr_clr !== 1'b1 || busy !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL clear_cycle: arr_clr=%b busy=%b m_valid=%b, want 1 1 0", arr_clr, busy, m_valid);
        if (arr_clr !== 1'b1 || busy !== 1'b1 || m_valid !== 1'b0) failures++;
    endtask

    // mode 0: ready tied high; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic drain(input int mode, input int nbeats, input logic [7:0] capmask, output int cycles);
        int    popped  = 0;
        int    cyc     = 0;
        logic  stalled = 1'b0;
        int    pat [4] = '{1, 0, 0, 1};
        beat_t held;
        beat_t got;
        beat_t exp;
        held = '0;
        while (popped < nbeats && sb.size() > 0 && cyc < 64) begin
            @(negedge clock);
            cyc++;
            capture = 1'b0;
            if (cyc < 8 && capmask[cyc]) begin
                capture = 1'b1;
                y_in    = rand_grid(100000);
                shift   = SHW'($urandom);
            end
            m_ready  = (mode == 0) ? 1'b1 : (pat[(cyc-1) % 4] != 0);
            got.row  = m_row;
            got.data = m_data;
            got.last = m_last;
            got.sat  = m_sat;
            checks++;
            if (arr_clr !== 1'b0) begin
                failures++;
                $display("FAIL arr_clr_stream: got %b want 0 at cycle %0d", arr_clr, cyc);
            end
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || got !== held) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%b beat=%h want valid=1 beat=%h", m_valid, got, held);
                end
            end
            if (m_valid === 1'b1 && m_ready) begin
                exp = sb.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL beat: got row=%0d data=%h last=%b sat=%b want row=%0d data=%h last=%b sat=%b",
                             got.row, got.data, got.last, got.sat, exp.row, exp.data, exp.last, exp.sat);
                end
                popped++;
                stalled = 1'b0;
            end else if (m_valid === 1'b1) begin
                stalled = 1'b1;
                held    = got;
            end else begin
                stalled = 1'b0;
            end
        end
        capture = 1'b0;
        cycles  = cyc;
        if (cyc >= 64) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: popped %0d beats, want %0d", popped, nbeats);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || arr_clr !== 1'b0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b m_valid=%b arr_clr=%b m_last=%b want 0 0 0 0",
                     name, busy, m_valid, arr_clr, m_last);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        capture = 1'b0;
        m_ready = 1'b0;
        shift   = '0;
        y_in    = rand_grid(100000);
        #22;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_sat !== 1'b0 ||
            m_row !== '0 || m_data !== '0 || arr_clr !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b valid=%b last=%b sat=%b row=%0d data=%h clr=%b want 0s and clr=1",
                     busy, m_valid, m_last, m_sat, m_row, m_data, arr_clr);
        end
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        checks++;
        if (arr_clr !== 1'b1) begin
            failures++;
            $display("FAIL reset_clr_hold: got %b want 1", arr_clr);
        end
        @(negedge clock);
        check_idle("reset_release");
    endtask

    task automatic test_basic_drain();
        grid_t g;
        int    cyc;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < C; j++)
                g[i][j] = 32'(16*i + j);
        push_grid(g, 0);
        do_capture(g, '0);
        drain(0, H, 8'h00, cyc);
        checks++;
        if (cyc !== H) begin
            failures++;
            $display("FAIL basic_cycles: got %0d want %0d", cyc, H);
        end
        @(negedge clock);
        check_idle("basic_end");
    endtask

    task automatic test_back_pressure();
        int cyc;
        grid_t g = rand_grid(1000000);
        push_grid(g, 3);
        do_capture(g, SHW'(3));
        drain(1, H, 8'h00, cyc);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bp_leftover: got %0d beats pending want 0", sb.size());
        end
        @(negedge clock);
        m_ready = 1'b1;
        check_idle("bp_end");
    endtask

    task automatic test_requant();
        int    cyc;
        grid_t g = rand_grid(200000);
        beat_t b;
        g[0][0] = 32'h0010_0000;  g[0][1] = 32'hFFF0_0000;
        g[0][2] = 32'hFFFF_FFEF;  g[0][3] = 32'd47;
        g[1][0] = 32'h0001_0000;  g[1][1] = 32'hFFFF_0000;
        g[1][2] = 32'hFFFF_FFEF;  g[1][3] = 32'd47;
        push_grid(g, 4);
        b.row = 2'd0; b.last = 1'b0; b.sat = 1'b1;
        b.data[0] = 16'h7FFF; b.data[1] = 16'h8000; b.data[2] = 16'hFFFE; b.data[3] = 16'h0002;
        sb[0] = b;
        b.row = 2'd1; b.sat = 1'b0;
        b.data[0] = 16'h1000; b.data[1] = 16'hF000; b.data[2] = 16'hFFFE; b.data[3] = 16'h0002;
        sb[1] = b;
        do_capture(g, SHW'(4));
        drain(0, H, 8'h00, cyc);
        @(negedge clock);
        check_idle("requant_end");
    endtask

    task automatic test_capture_busy();
        int    cyc;
        grid_t g = rand_grid(50000);
        push_grid(g, 1);
        do_capture(g, SHW'(1));
        drain(0, H, 8'b0001_0100, cyc);
        @(negedge clock);
        capture = 1'b0;
        check_idle("capture_busy_end");
        @(negedge clock);
        check_idle("capture_busy_settle");
    endtask

    task automatic test_async_reset();
        int    cyc;
        grid_t g = rand_grid(30000);
        push_grid(g, 2);
        do_capture(g, SHW'(2));
        drain(0, 2, 8'h00, cyc);
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || arr_clr !== 1'b1 || m_row !== '0 || m_data !== '0) begin
            failures++;
            $display("FAIL async_reset: valid=%b busy=%b clr=%b row=%0d data=%h want 0 0 1 0 0",
                     m_valid, busy, arr_clr, m_row, m_data);
        end
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check_idle("async_release");
        g = rand_grid(30000);
        push_grid(g, 0);
        do_capture(g, '0);
        drain(0, H, 8'h00, cyc);
        checks++;
        if (cyc !== H) begin
            failures++;
            $display("FAIL async_redrain_cycles: got %0d want %0d", cyc, H);
        end
        @(negedge clock);
        check_idle("async_redrain_end");
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_back_pressure();
        test_requant();
        test_capture_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
